// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// default reset PC and legal instruction memory window.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_HI  = 32'h0000_4FFC;

  // A fetch address is legal when word aligned and inside [lo, hi].
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_skid.sv
// One-entry parking buffer for a fetched word (instruction + PC) that
// arrived while the IF/ID register was still occupied by a stalled instruction.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        full_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;

  // Capture a word on load, release it on drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_r  <= 1'b0;
      instr_r <= 32'd0;
      pc_r    <= 32'd0;
    end else if (load) begin
      full_r  <= 1'b1;
      instr_r <= load_instr;
      pc_r    <= load_pc;
    end else if (drain) begin
      full_r  <= 1'b0;
    end else begin
      full_r  <= full_r;
    end
  end

  assign full  = full_r;
  assign instr = instr_r;
  assign pc    = pc_r;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer. Issues one fetch
// at a time, fills IF/ID, parks a word in the skid buffer under ID stalls,
// applies delay-slot redirects and stops on an illegal fetch address.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IMEM_LO  = DEF_IMEM_LO,
  parameter logic [31:0] IMEM_HI  = DEF_IMEM_HI
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        fault,
  output logic [31:0] fault_pc
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s, seq_pc_s;
  logic         pend_valid_r, pend_valid_nxt_s;
  logic [31:0]  pend_pc_r, pend_pc_nxt_s;
  logic         imem_req_r;
  logic         if_valid_r;
  logic [31:0]  if_instr_r, if_pc_r, if_pc4_r;
  logic         fault_r;
  logic [31:0]  fault_pc_r;

  logic         slot_free_s, accept_s;
  logic         ifid_load_s, ifid_from_skid_s, ifid_bubble_s;
  logic         skid_load_s, skid_drain_s, fault_set_s;
  logic         skid_full_s;
  logic [31:0]  skid_instr_s, skid_pc_s;

  assign slot_free_s = !if_valid_r || !stall_d;
  assign accept_s    = redirect && if_valid_r && !stall_d && !pend_valid_r;
  assign seq_pc_s    = pc_r + 32'd4;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (skid_load_s),
    .drain      (skid_drain_s),
    .load_instr (imem_rdata),
    .load_pc    (pc_r),
    .full       (skid_full_s),
    .instr      (skid_instr_s),
    .pc         (skid_pc_s)
  );

  // Next-state, next-PC and IF/ID / skid control decisions.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_pc_nxt_s    = pend_pc_r;
    ifid_load_s      = 1'b0;
    ifid_from_skid_s = 1'b0;
    ifid_bubble_s    = 1'b0;
    skid_load_s      = 1'b0;
    skid_drain_s     = 1'b0;
    fault_set_s      = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          // This ack is the delay slot when a redirect is pending or accepted now.
          if (accept_s) begin
            pc_nxt_s = redirect_pc;
          end else if (pend_valid_r) begin
            pc_nxt_s = pend_pc_r;
          end else begin
            pc_nxt_s = seq_pc_s;
          end
          pend_valid_nxt_s = 1'b0;
          if (slot_free_s) begin
            ifid_load_s = 1'b1;
          end else begin
            skid_load_s = 1'b1;
            state_nxt_s = ST_HOLD;
          end
        end else begin
          if (accept_s) begin
            pend_valid_nxt_s = 1'b1;
            pend_pc_nxt_s    = redirect_pc;
          end else begin
            pend_valid_nxt_s = pend_valid_r;
          end
          ifid_bubble_s = slot_free_s;
        end
      end
      ST_HOLD: begin
        if (!stall_d && skid_full_s) begin
          skid_drain_s     = 1'b1;
          ifid_load_s      = 1'b1;
          ifid_from_skid_s = 1'b1;
          state_nxt_s      = ST_REQ;
          // The parked word is the delay slot of a branch leaving ID now,
          // so the pc (already past it) is replaced by the target directly.
          if (accept_s) begin
            pc_nxt_s = redirect_pc;
          end else begin
            pc_nxt_s = pc_r;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        ifid_bubble_s = slot_free_s;
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
    // Never raise a request for an illegal address: divert to FAULT instead.
    if ((state_nxt_s == ST_REQ) && !pc_legal(pc_nxt_s, IMEM_LO, IMEM_HI)) begin
      state_nxt_s = ST_FAULT;
      fault_set_s = 1'b1;
    end else begin
      fault_set_s = 1'b0;
    end
  end

  // FSM state, program counter, pending redirect, request and fault registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_PC;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= 32'd0;
      imem_req_r   <= 1'b0;
      fault_r      <= 1'b0;
      fault_pc_r   <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
      imem_req_r   <= (state_nxt_s == ST_REQ);
      if (fault_set_s) begin
        fault_r    <= 1'b1;
        fault_pc_r <= pc_nxt_s;
      end
    end
  end

  // IF/ID register: load from memory or skid, bubble when consumed, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_valid_r <= 1'b0;
      if_instr_r <= 32'd0;
      if_pc_r    <= 32'd0;
      if_pc4_r   <= 32'd0;
    end else if (ifid_load_s) begin
      if_valid_r <= 1'b1;
      if (ifid_from_skid_s) begin
        if_instr_r <= skid_instr_s;
        if_pc_r    <= skid_pc_s;
        if_pc4_r   <= skid_pc_s + 32'd4;
      end else begin
        if_instr_r <= imem_rdata;
        if_pc_r    <= pc_r;
        if_pc4_r   <= seq_pc_s;
      end
    end else if (ifid_bubble_s) begin
      if_valid_r <= 1'b0;
    end else begin
      if_valid_r <= if_valid_r;
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;
  assign if_valid  = if_valid_r;
  assign if_instr  = if_instr_r;
  assign if_pc     = if_pc_r;
  assign if_pc4    = if_pc4_r;
  assign fault     = fault_r;
  assign fault_pc  = fault_pc_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a small latency-programmable
// instruction memory model driven from tasks.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fault;
  logic [31:0] fault_pc;

  int total = 0;
  int bad   = 0;
  int wait_cnt = 0;

  pc_fetch_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .fault       (fault),
    .fault_pc    (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of memory: ack after lat cycles of a held request.
  task automatic mem_cycle(input int lat, input logic stall, input logic redir,
                           input logic [31:0] rpc);
    logic req_now, ack_now;
    req_now     = imem_req;
    ack_now     = imem_req && (wait_cnt >= lat - 1);
    imem_ack    = ack_now;
    imem_rdata  = word_at(imem_addr);
    stall_d     = stall;
    redirect    = redir;
    redirect_pc = rpc;
    tick();
    if (req_now && ack_now) wait_cnt = 0;
    else if (req_now) wait_cnt = wait_cnt + 1;
    else wait_cnt = 0;
    imem_ack = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0; wait_cnt = 0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic run_to_ifpc(input int lat, input logic [31:0] target);
    int n;
    n = 0;
    while (!(if_valid && if_pc == target) && n < 100) begin
      mem_cycle(lat, 1'b0, 1'b0, 32'd0);
      n++;
    end
    total++;
    if (n >= 100) begin
      $display("FAIL reach_ifpc timeout got if_pc=%h need=%h", if_pc, target);
      bad++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0; wait_cnt = 0;
    tick();
    total++; if (imem_req !== 1'b0) begin $display("FAIL rst_req got=%b need=0", imem_req); bad++; end
    total++; if (imem_addr !== 32'h0000_3000) begin $display("FAIL rst_addr got=%h need=00003000", imem_addr); bad++; end
    total++; if ({if_valid, if_instr, if_pc, if_pc4} !== 97'd0) begin $display("FAIL rst_ifid got=%b/%h/%h/%h need=0", if_valid, if_instr, if_pc, if_pc4); bad++; end
    total++; if ({fault, fault_pc} !== 33'd0) begin $display("FAIL rst_fault got=%b/%h need=0", fault, fault_pc); bad++; end
    reset_n = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin $display("FAIL boot_first_req got=%b/%h need=1/00003000", imem_req, imem_addr); bad++; end
  endtask

  task automatic test_zero_wait_stream();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a = 32'h0000_3000 + 32'(4 * i);
      total++; if (imem_req !== 1'b1 || imem_addr !== a) begin $display("FAIL stream_addr%0d got=%b/%h need=1/%h", i, imem_req, imem_addr, a); bad++; end
      if (i > 0) begin
        total++;
        if (if_valid !== 1'b1 || if_pc !== a - 32'd4 || if_pc4 !== a || if_instr !== word_at(a - 32'd4)) begin
          $display("FAIL stream_ifid%0d got=%b/%h/%h/%h need pc=%h", i, if_valid, if_pc, if_pc4, if_instr, a - 32'd4); bad++;
        end
      end else begin
        total++; if (if_valid !== 1'b0) begin $display("FAIL stream_ifv0 got=%b need=0", if_valid); bad++; end
      end
      mem_cycle(1, 1'b0, 1'b0, 32'd0);
    end
  endtask

  task automatic test_stall_during_fetch();
    do_reset();
    mem_cycle(1, 1'b0, 1'b0, 32'd0);
    mem_cycle(1, 1'b0, 1'b0, 32'd0);
    total++; if (imem_addr !== 32'h0000_3008 || if_pc !== 32'h0000_3004) begin $display("FAIL stall_pre got=%h/%h need=00003008/00003004", imem_addr, if_pc); bad++; end
    for (int i = 0; i < 3; i++) begin
      mem_cycle(1, 1'b1, 1'b0, 32'd0);
      total++;
      if (imem_req !== 1'b0 || if_pc !== 32'h0000_3004 || if_valid !== 1'b1) begin
        $display("FAIL stall_hold%0d got req=%b if_pc=%h v=%b need 0/00003004/1", i, imem_req, if_pc, if_valid); bad++;
      end
    end
    mem_cycle(1, 1'b0, 1'b0, 32'd0);
    total++; if (if_pc !== 32'h0000_3008 || if_instr !== word_at(32'h0000_3008) || if_pc4 !== 32'h0000_300C) begin $display("FAIL stall_release got=%h/%h/%h need pc=00003008", if_pc, if_instr, if_pc4); bad++; end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_300C) begin $display("FAIL stall_resume got=%b/%h need=1/0000300c", imem_req, imem_addr); bad++; end
    mem_cycle(1, 1'b0, 1'b0, 32'd0);
    total++; if (if_pc !== 32'h0000_300C || if_valid !== 1'b1) begin $display("FAIL stall_after got=%h/%b need=0000300c/1", if_pc, if_valid); bad++; end
  endtask

  task automatic test_branch(input int redir_lat, input string tag);
    do_reset();
    run_to_ifpc(2, 32'h0000_3010);
    total++; if (imem_addr !== 32'h0000_3014 || imem_req !== 1'b1) begin $display("FAIL %s_inflight got=%b/%h need=1/00003014", tag, imem_req, imem_addr); bad++; end
    mem_cycle(redir_lat, 1'b0, 1'b1, 32'h0000_3100);
    if (redir_lat == 2) begin
      total++; if (if_valid !== 1'b0 || imem_addr !== 32'h0000_3014) begin $display("FAIL %s_wait got=%b/%h need=0/00003014", tag, if_valid, imem_addr); bad++; end
      mem_cycle(2, 1'b0, 1'b0, 32'd0);
    end
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3014 || if_instr !== word_at(32'h0000_3014)) begin $display("FAIL %s_dslot got=%b/%h/%h need pc=00003014", tag, if_valid, if_pc, if_instr); bad++; end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3100) begin $display("FAIL %s_target got=%b/%h need=1/00003100", tag, imem_req, imem_addr); bad++; end
    mem_cycle(2, 1'b0, 1'b0, 32'd0);
    mem_cycle(2, 1'b0, 1'b0, 32'd0);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3100 || if_pc4 !== 32'h0000_3104) begin $display("FAIL %s_tgt_ifid got=%b/%h/%h need pc=00003100", tag, if_valid, if_pc, if_pc4); bad++; end
  endtask

  task automatic test_misaligned_jump();
    do_reset();
    run_to_ifpc(2, 32'h0000_3010);
    mem_cycle(2, 1'b0, 1'b1, 32'h0000_3102);
    total++; if (fault !== 1'b0) begin $display("FAIL jr_early_fault got=%b need=0", fault); bad++; end
    mem_cycle(2, 1'b0, 1'b0, 32'd0);
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3014) begin $display("FAIL jr_dslot got=%b/%h need=1/00003014", if_valid, if_pc); bad++; end
    total++; if (fault !== 1'b1 || fault_pc !== 32'h0000_3102 || imem_req !== 1'b0) begin $display("FAIL jr_fault got=%b/%h req=%b need=1/00003102/0", fault, fault_pc, imem_req); bad++; end
    mem_cycle(2, 1'b0, 1'b0, 32'd0);
    total++; if (if_valid !== 1'b0) begin $display("FAIL jr_drain got=%b need=0", if_valid); bad++; end
    for (int i = 0; i < 3; i++) mem_cycle(2, 1'b0, 1'b0, 32'd0);
    total++; if (imem_req !== 1'b0 || fault !== 1'b1 || fault_pc !== 32'h0000_3102) begin $display("FAIL jr_sticky got=%b/%b/%h need=0/1/00003102", imem_req, fault, fault_pc); bad++; end
  endtask

  task automatic test_out_of_range();
    logic [31:0] last_addr;
    int n;
    do_reset();
    last_addr = 32'd0;
    n = 0;
    while (!fault && n < 2200) begin
      if (imem_req) last_addr = imem_addr;
      mem_cycle(1, 1'b0, 1'b0, 32'd0);
      n++;
    end
    total++; if (fault !== 1'b1 || fault_pc !== 32'h0000_5000) begin $display("FAIL oor_fault got=%b/%h need=1/00005000", fault, fault_pc); bad++; end
    total++; if (last_addr !== 32'h0000_4FFC || imem_req !== 1'b0) begin $display("FAIL oor_last_req got=%h req=%b need=00004ffc/0", last_addr, imem_req); bad++; end
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_4FFC || if_pc4 !== 32'h0000_5000) begin $display("FAIL oor_ifid got=%b/%h/%h need=1/00004ffc/00005000", if_valid, if_pc, if_pc4); bad++; end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0000_3000 || {if_valid, if_instr, if_pc, if_pc4} !== 97'd0 || {fault, fault_pc} !== 33'd0) begin
      $display("FAIL oor_async_reset got req=%b addr=%h v=%b pc=%h fault=%b fpc=%h need reset values", imem_req, imem_addr, if_valid, if_pc, fault, fault_pc); bad++;
    end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_wait_stream();
    test_stall_during_fetch();
    test_branch(2, "br2");
    test_branch(1, "br_same");
    test_misaligned_jump();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
